// File: rtl/hopfield_pkg.sv
// Shared types and helpers for the Hopfield recall engine.
// Holds the FSM states, the bit-to-sign map and the saturating add.
package hopfield_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEARN,
    S_RECALL,
    S_DONE
  } hop_state_t;

  // Accumulator width for N neurons with WW-bit weights.
  function automatic int acc_width(input int n, input int ww);
    return ww + $clog2(n) + 1;
  endfunction

  // Default accumulator width for the default N=8, WW=8 build.
  localparam int ACC_W = 12;

  function automatic int bit_sign(input logic b);
    return b ? 1 : -1;
  endfunction

  // Symmetric clamp: the most negative code is never produced.
  function automatic int sat_add(input int a, input int b, input int ww);
    int lim;
    int s;
    lim = (1 << (ww - 1)) - 1;
    s = a + b;
    if (s > lim) s = lim;
    else if (s < -lim) s = -lim;
    return s;
  endfunction

endpackage

// File: rtl/hebbian_row_update.sv
// One row of saturating Hebbian weight updates.
// Row storage skips the diagonal: entry k maps to column k or k+1.
module hebbian_row_update
  import hopfield_pkg::*;
#(
  parameter int N  = 8,
  parameter int WW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-2:0][WW-1:0] row_in,
  input  logic [N-1:0]         p,
  input  logic [IW-1:0]        r,
  output logic [N-2:0][WW-1:0] row_out
);

  // Add p_r*p_j to every off-diagonal entry of row r.
  always_comb begin
    int jj;
    int d;
    row_out = '0;
    jj = 0;
    d = 0;
    for (int k = 0; k < N - 1; k++) begin
      jj = (k < int'(r)) ? k : k + 1;
      d = bit_sign(p[r]) * bit_sign(p[jj]);
      row_out[k] = WW'(sat_add(int'($signed(row_in[k])), d, WW));
    end
  end

endmodule

// File: rtl/hopfield_recall_engine.sv
// Time-multiplexed Hopfield memory with Hebbian learning.
// One synapse per cycle through a shared add/subtract MAC.
module hopfield_recall_engine
  import hopfield_pkg::*;
#(
  parameter int N          = 8,
  parameter int WW         = 8,
  parameter int MAX_SWEEPS = 16,
  localparam int SW = $clog2(MAX_SWEEPS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic          clear,
  input  logic [N-1:0]  pattern_in,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [SW-1:0] sweeps,
  output logic [N-1:0]  state_out
);

  localparam int IW = $clog2(N);
  localparam int AW = acc_width(N, WW);

  hop_state_t st;

  logic [N-2:0][WW-1:0] w [N];
  logic [N-2:0][WW-1:0] row_new;

  logic [N-1:0]          p;
  logic [IW-1:0]         r;
  logic [IW-1:0]         i;
  logic [IW-1:0]         j;
  logic signed [AW-1:0]  acc;
  logic                  chg;

  logic [IW-1:0]         k;
  logic signed [WW-1:0]  wsel;
  logic signed [AW-1:0]  term;
  logic signed [AW-1:0]  sum;
  logic                  new_si;
  logic                  chg_n;
  logic [SW-1:0]         sweeps_n;

  hebbian_row_update #(
    .N  (N),
    .WW (WW)
  ) u_row (
    .row_in  (w[r]),
    .p       (p),
    .r       (r),
    .row_out (row_new)
  );

  // Shared MAC: pick w[i][j], add or subtract by s_j, decide s_i.
  always_comb begin
    k = '0;
    if (j > i) k = j - 1'b1;
    else if (j < i) k = j;
    wsel = $signed(w[i][k]);
    term = '0;
    if (j != i) term = state_out[j] ? AW'(wsel) : -AW'(wsel);
    sum = acc + term;
    new_si = state_out[i];
    if (sum > 0) new_si = 1'b1;
    else if (sum < 0) new_si = 1'b0;
    chg_n = chg | (new_si != state_out[i]);
    sweeps_n = sweeps + 1'b1;
  end

  // Command FSM, weight array and recall datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      sweeps    <= '0;
      state_out <= '0;
      p         <= '0;
      r         <= '0;
      i         <= '0;
      j         <= '0;
      acc       <= '0;
      chg       <= 1'b0;
      for (int a = 0; a < N; a++) w[a] <= '0;
    end else begin
      done <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (clear) begin
            for (int a = 0; a < N; a++) w[a] <= '0;
          end else if (start) begin
            converged <= 1'b0;
            sweeps    <= '0;
            busy      <= 1'b1;
            if (mode) begin
              p  <= pattern_in;
              r  <= '0;
              st <= S_LEARN;
            end else begin
              state_out <= pattern_in;
              i   <= '0;
              j   <= '0;
              acc <= '0;
              chg <= 1'b0;
              st  <= S_RECALL;
            end
          end
        end
        S_LEARN: begin
          w[r] <= row_new;
          if (r == IW'(N - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
            st   <= S_DONE;
          end else begin
            r <= r + 1'b1;
          end
        end
        S_RECALL: begin
          if (j == IW'(N - 1)) begin
            state_out[i] <= new_si;
            acc <= '0;
            j   <= '0;
            if (i == IW'(N - 1)) begin
              sweeps <= sweeps_n;
              if (!chg_n) begin
                converged <= 1'b1;
                busy <= 1'b0;
                done <= 1'b1;
                st   <= S_DONE;
              end else if (sweeps_n == SW'(MAX_SWEEPS)) begin
                converged <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
                st   <= S_DONE;
              end else begin
                chg <= 1'b0;
                i   <= '0;
              end
            end else begin
              chg <= chg_n;
              i   <= i + 1'b1;
            end
          end else begin
            acc <= sum;
            j   <= j + 1'b1;
          end
        end
        S_DONE: begin
          st <= S_IDLE;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hopfield_recall_engine.sv
// Scoreboard bench for hopfield_recall_engine.
// Directed learn/recall vectors, two builds (MAX_SWEEPS 16 and 1).
module tb_hopfield_recall_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       mode = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] pattern_in = 8'h00;

  logic       busy0, done0, conv0;
  logic [4:0] sweeps0;
  logic [7:0] state0;
  logic       busy1, done1, conv1;
  logic [0:0] sweeps1;
  logic [7:0] state1;

  int errors = 0;
  int checks = 0;
  int bc0 = 0;
  int bc1 = 0;
  int dcnt0 = 0;

  typedef struct {
    int unit;
    int st;
    int cv;
    int sw;
    int bc;
  } exp_t;

  exp_t sb[$];

  hopfield_recall_engine #(
    .N(8), .WW(8), .MAX_SWEEPS(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start0), .mode(mode),
    .clear(clear), .pattern_in(pattern_in), .busy(busy0),
    .done(done0), .converged(conv0), .sweeps(sweeps0),
    .state_out(state0)
  );

  hopfield_recall_engine #(
    .N(8), .WW(8), .MAX_SWEEPS(1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode),
    .clear(clear), .pattern_in(pattern_in), .busy(busy1),
    .done(done1), .converged(conv1), .sweeps(sweeps1),
    .state_out(state1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic on_done(input int unit, input int so, input int cv,
                         input int sw, input int bc, input logic bz);
    exp_t e;
    chk("done_busy_overlap", int'(bz), 0);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: unit %0d got done, expected none", unit);
    end else begin
      e = sb.pop_front();
      chk("unit", unit, e.unit);
      chk("state_out", so, e.st);
      chk("converged", cv, e.cv);
      chk("sweeps", sw, e.sw);
      chk("busy_cycles", bc, e.bc);
    end
  endtask

  // Monitor: count busy cycles, compare each done against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      bc0 = 0;
      bc1 = 0;
    end else begin
      if (busy0) bc0++;
      if (busy1) bc1++;
      if (done0) begin
        dcnt0++;
        on_done(0, int'(state0), int'(conv0), int'(sweeps0), bc0, busy0);
        bc0 = 0;
      end
      if (done1) begin
        on_done(1, int'(state1), int'(conv1), int'(sweeps1), bc1, busy1);
        bc1 = 0;
      end
    end
  end

  function automatic int wt(input int i, input int j);
    int k;
    logic signed [7:0] v;
    k = (j > i) ? j - 1 : j;
    v = $signed(dut.w[i][k]);
    return int'(v);
  endfunction

  function automatic int wzero();
    int nz;
    nz = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (i != j && wt(i, j) != 0) nz++;
    return nz;
  endfunction

  task automatic set_start(input int unit, input logic v);
    if (unit == 0) start0 = v;
    else start1 = v;
  endtask

  task automatic issue(input int unit, input logic md, input logic [7:0] pat);
    @(posedge clk);
    #1;
    mode = md;
    pattern_in = pat;
    set_start(unit, 1'b1);
    @(posedge clk);
    #1;
    set_start(unit, 1'b0);
  endtask

  task automatic wait_done(input int unit);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ((unit == 0) ? done0 : done1) break;
    end
    if (n == 3000) begin
      checks++;
      errors++;
      $display("FAIL timeout: unit %0d no done in 3000 cycles", unit);
    end
  endtask

  task automatic run(input int unit, input logic md, input logic [7:0] pat,
                     input int es, input int ec, input int ew, input int eb);
    sb.push_back('{unit, es, ec, ew, eb});
    issue(unit, md, pat);
    wait_done(unit);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_conv", int'(conv0), 0);
    chk("rst_sweeps", int'(sweeps0), 0);
    chk("rst_state", int'(state0), 0);
    chk("rst_state1", int'(state1), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Zero weights: every sum ties, cue is kept.
    run(0, 1'b0, 8'h5A, 8'h5A, 1, 1, 64);

    run(0, 1'b1, 8'hAA, 8'h5A, 0, 0, 8);
    chk("w01_learn", wt(0, 1), -1);
    chk("w02_learn", wt(0, 2), 1);
    chk("w10_learn", wt(1, 0), -1);
    chk("w76_learn", wt(7, 6), -1);

    // Recall with a learn start injected mid-run; it must be ignored.
    sb.push_back('{0, 8'hAA, 1, 2, 128});
    issue(0, 1'b0, 8'hAB);
    repeat (10) @(posedge clk);
    #1;
    mode = 1'b1;
    pattern_in = 8'h00;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done(0);
    chk("w01_after_ign", wt(0, 1), -1);
    chk("w02_after_ign", wt(0, 2), 1);

    // Sweep limit of one.
    run(1, 1'b1, 8'hAA, 8'h00, 0, 0, 8);
    run(1, 1'b0, 8'hAB, 8'hAA, 0, 1, 64);

    // Saturation.
    for (int n = 0; n < 200; n++)
      run(0, 1'b1, 8'hAA, 8'hAA, 0, 0, 8);
    chk("w01_sat", wt(0, 1), -127);
    chk("w02_sat", wt(0, 2), 127);
    chk("w21_sat", wt(2, 1), -127);
    chk("w53_sat", wt(5, 3), 127);
    run(0, 1'b0, 8'hAB, 8'hAA, 1, 2, 128);

    // Reset in the middle of a recall.
    issue(0, 1'b0, 8'hAB);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_done", int'(done0), 0);
    chk("mid_rst_conv", int'(conv0), 0);
    chk("mid_rst_sweeps", int'(sweeps0), 0);
    chk("mid_rst_state", int'(state0), 0);
    chk("mid_rst_wnz", wzero(), 0);
    begin
      int d0;
      d0 = dcnt0;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (200) @(posedge clk);
      chk("no_done_after_rst", dcnt0, d0);
    end

    // clear and start together: clear wins, start dropped.
    run(0, 1'b1, 8'hAA, 8'h00, 0, 0, 8);
    chk("w01_pre_clear", wt(0, 1), -1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    mode = 1'b1;
    pattern_in = 8'hFF;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("clear_busy", int'(busy0), 0);
    chk("clear_wnz", wzero(), 0);
    repeat (20) @(posedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
